// File: rtl/charge_pkg.sv
// Shared types, default sizes and counter helpers for the charge meter.
package charge_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;
  localparam int TMO_DEF   = 64;
  localparam int COST_W    = 8;
  localparam int CNT_W     = 16;
  localparam int TMO_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POLICY = 2'd1,
    ST_MULT   = 2'd2,
    ST_ACCUM  = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

  function automatic logic [TMO_CNT_W-1:0] sat_inc_tmo(input logic [TMO_CNT_W-1:0] v);
    return (v == {TMO_CNT_W{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/charge_mult.sv
// Serial shift-add multiplier: one multiplier bit per cycle, A_W cycles per product.
// product/done are presented combinationally during the final step so the caller can commit that edge.
module charge_mult import charge_pkg::*; #(
  parameter int A_W = LEN_W_DEF,
  parameter int B_W = COST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [A_W+B_W-1:0] product,
  output logic             done
);

  localparam int P_W  = A_W + B_W;
  localparam int CW   = $clog2(A_W + 1);

  logic           busy_q, busy_d;
  logic [A_W-1:0] a_q, a_d;
  logic [P_W-1:0] b_q, b_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0] step_s;
  logic           last_s;

  always_comb begin
    step_s = acc_q + (a_q[0] ? b_q : {P_W{1'b0}});
    last_s = busy_q && (cnt_q == CW'(A_W - 1));
    busy_d = busy_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = 1'b0;
      a_d    = {A_W{1'b0}};
      b_d    = {P_W{1'b0}};
      acc_d  = {P_W{1'b0}};
      cnt_d  = {CW{1'b0}};
    end else if (start) begin
      busy_d = 1'b1;
      a_d    = a;
      b_d    = {{A_W{1'b0}}, b};
      acc_d  = {P_W{1'b0}};
      cnt_d  = {CW{1'b0}};
    end else if (busy_q) begin
      acc_d  = step_s;
      a_d    = a_q >> 1'b1;
      b_d    = b_q << 1'b1;
      cnt_d  = cnt_q + CW'(1);
      busy_d = !last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      a_q    <= {A_W{1'b0}};
      b_q    <= {P_W{1'b0}};
      acc_q  <= {P_W{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      busy_q <= busy_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign product = step_s;
  assign done    = last_s;

endmodule

// File: rtl/charge_meter.sv
// Per-transaction charge meter: policy handshake, serial cost multiply, saturating accumulation.
module charge_meter import charge_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic                 asclk,
  input  logic                 areset,
  input  logic                 txn_valid,
  output logic                 txn_ready,
  input  logic                 txn_wr,
  input  logic [LEN_W-1:0]     txn_len,
  input  logic                 check_policy,
  input  logic                 check_false_policy,
  input  logic [COST_W-1:0]    cfg_wr_cost,
  input  logic [COST_W-1:0]    cfg_rd_cost,
  input  logic [ACC_W-1:0]     cfg_budget,
  input  logic                 clr,
  output logic [ACC_W-1:0]     charge_total,
  output logic [CNT_W-1:0]     grant_cnt,
  output logic [CNT_W-1:0]     deny_cnt,
  output logic [TMO_CNT_W-1:0] tmo_cnt,
  output logic                 charge_done,
  output logic                 over_budget
);

  localparam int PROD_W = LEN_W + COST_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam int WAIT_W = $clog2(TMO + 1);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [COST_W-1:0]      cost_q, cost_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [ACC_W-1:0]       total_q, total_d;
  logic [CNT_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]       deny_q, deny_d;
  logic [TMO_CNT_W-1:0]   tmo_q, tmo_d;
  logic                   done_q, done_d;
  logic                   over_q, over_d;

  logic                   accept_s;
  logic                   mult_start_s;
  logic                   mult_done_s;
  logic [PROD_W-1:0]      mult_product_s;
  logic [SUM_W-1:0]       sum_s;

  assign txn_ready = (state_q == ST_IDLE) && !over_q;

  always_comb begin
    accept_s     = txn_valid && txn_ready;
    sum_s        = SUM_W'(total_q) + SUM_W'(mult_product_s);
    state_d      = state_q;
    len_d        = len_q;
    cost_d       = cost_q;
    wait_d       = wait_q;
    total_d      = total_q;
    grant_d      = grant_q;
    deny_d       = deny_q;
    tmo_d        = tmo_q;
    done_d       = 1'b0;
    over_d       = (total_q >= cfg_budget);
    mult_start_s = 1'b0;
    // clr outranks everything, including a coincident accept
    if (clr) begin
      state_d = ST_IDLE;
      wait_d  = {WAIT_W{1'b0}};
      total_d = {ACC_W{1'b0}};
      grant_d = {CNT_W{1'b0}};
      deny_d  = {CNT_W{1'b0}};
      tmo_d   = {TMO_CNT_W{1'b0}};
      over_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            len_d   = txn_len;
            cost_d  = txn_wr ? cfg_wr_cost : cfg_rd_cost;
            wait_d  = {WAIT_W{1'b0}};
            state_d = ST_POLICY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_POLICY: begin
          if (check_false_policy) begin
            deny_d  = sat_inc_cnt(deny_q);
            state_d = ST_IDLE;
          end else if (check_policy) begin
            mult_start_s = 1'b1;
            state_d      = ST_MULT;
          end else if (wait_q == WAIT_W'(TMO - 1)) begin
            tmo_d   = sat_inc_tmo(tmo_q);
            state_d = ST_IDLE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_MULT: begin
          // commit on the final multiply step so results show in the ACCUM cycle
          if (mult_done_s) begin
            total_d = (|sum_s[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
            grant_d = sat_inc_cnt(grant_q);
            done_d  = 1'b1;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_MULT;
          end
        end
        ST_ACCUM: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge asclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      len_q   <= {LEN_W{1'b0}};
      cost_q  <= {COST_W{1'b0}};
      wait_q  <= {WAIT_W{1'b0}};
      total_q <= {ACC_W{1'b0}};
      grant_q <= {CNT_W{1'b0}};
      deny_q  <= {CNT_W{1'b0}};
      tmo_q   <= {TMO_CNT_W{1'b0}};
      done_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cost_q  <= cost_d;
      wait_q  <= wait_d;
      total_q <= total_d;
      grant_q <= grant_d;
      deny_q  <= deny_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      over_q  <= over_d;
    end
  end

  charge_mult #(
    .A_W (LEN_W),
    .B_W (COST_W)
  ) u_mult (
    .clk     (asclk),
    .rst     (areset),
    .flush   (clr),
    .start   (mult_start_s),
    .a       (len_q),
    .b       (cost_q),
    .product (mult_product_s),
    .done    (mult_done_s)
  );

  assign charge_total = total_q;
  assign grant_cnt    = grant_q;
  assign deny_cnt     = deny_q;
  assign tmo_cnt      = tmo_q;
  assign charge_done  = done_q;
  assign over_budget  = over_q;

endmodule

// File: tb/tb_charge_meter.sv
// Scoreboard bench for charge_meter: grants push expected results, a monitor checks each charge_done.
module tb_charge_meter;

  localparam int ACC_W = 24;
  localparam int LEN_W = 8;
  localparam int TMO   = 64;

  logic             asclk = 1'b0;
  logic             areset, txn_valid, txn_wr, check_policy, check_false_policy, clr;
  logic [LEN_W-1:0] txn_len;
  logic [7:0]       cfg_wr_cost, cfg_rd_cost;
  logic [ACC_W-1:0] cfg_budget;
  logic             txn_ready, charge_done, over_budget;
  logic [ACC_W-1:0] charge_total;
  logic [15:0]      grant_cnt, deny_cnt;
  logic [7:0]       tmo_cnt;

  typedef struct {
    int     cyc;
    longint total;
    longint grants;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  longint model_total  = 0;
  longint model_grants = 0;

  charge_meter #(.ACC_W(ACC_W), .LEN_W(LEN_W), .TMO(TMO)) dut (
    .asclk              (asclk),
    .areset             (areset),
    .txn_valid          (txn_valid),
    .txn_ready          (txn_ready),
    .txn_wr             (txn_wr),
    .txn_len            (txn_len),
    .check_policy       (check_policy),
    .check_false_policy (check_false_policy),
    .cfg_wr_cost        (cfg_wr_cost),
    .cfg_rd_cost        (cfg_rd_cost),
    .cfg_budget         (cfg_budget),
    .clr                (clr),
    .charge_total       (charge_total),
    .grant_cnt          (grant_cnt),
    .deny_cnt           (deny_cnt),
    .tmo_cnt            (tmo_cnt),
    .charge_done        (charge_done),
    .over_budget        (over_budget)
  );

  always #5 asclk = ~asclk;

  always @(posedge asclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every charge_done must match the oldest expected grant result
  always @(negedge asclk) begin
    if (charge_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got charge_done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("sb_charge_total", charge_total, mon_e.total);
        check("sb_grant_cnt", grant_cnt, mon_e.grants);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge asclk);
    #1;
  endtask

  task automatic accept(input logic wr, input int len);
    int w = 0;
    while (txn_ready !== 1'b1 && w < 100) begin
      step(1);
      w++;
    end
    if (w >= 100) check("accept_ready_wait", 0, 1);
    txn_valid = 1'b1;
    txn_wr    = wr;
    txn_len   = LEN_W'(len);
    step(1);
    txn_valid = 1'b0;
  endtask

  task automatic grant(input longint prod);
    exp_t e;
    if (model_grants < 65535) model_grants++;
    model_total += prod;
    if (model_total > 64'hFFFFFF) model_total = 64'hFFFFFF;
    e.cyc    = cyc + LEN_W + 1;
    e.total  = model_total;
    e.grants = model_grants;
    sb_q.push_back(e);
    check_policy = 1'b1;
    step(1);
    check_policy = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 40) begin
      step(1);
      w++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    model_total  = 0;
    model_grants = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1; txn_valid = 1'b0; txn_wr = 1'b0; txn_len = '0;
    check_policy = 1'b0; check_false_policy = 1'b0; clr = 1'b0;
    cfg_wr_cost = 8'd3; cfg_rd_cost = 8'd5; cfg_budget = 24'hFFFFFF;
    step(3);
    areset = 1'b0;
    step(1);
    check("rst_txn_ready", txn_ready, 1);
    check("rst_charge_total", charge_total, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    check("rst_deny_cnt", deny_cnt, 0);
    check("rst_tmo_cnt", tmo_cnt, 0);
    check("rst_charge_done", charge_done, 0);
    check("rst_over_budget", over_budget, 0);

    // write len 4 cost 3, grant in the fifth POLICY cycle
    accept(1'b1, 4);
    step(4);
    grant(12);
    drain();
    check("w4_grant_cnt", grant_cnt, 1);
    check("w4_ready_after", txn_ready, 1);

    // read with both pulses together: deny wins
    accept(1'b0, 2);
    check_policy = 1'b1; check_false_policy = 1'b1;
    step(1);
    check_policy = 1'b0; check_false_policy = 1'b0;
    check("deny_cnt", deny_cnt, 1);
    check("deny_ready", txn_ready, 1);
    check("deny_total", charge_total, 12);
    check("deny_grants", grant_cnt, 1);

    // zero-length write still grants; read uses rd cost
    accept(1'b1, 0);
    grant(0);
    drain();
    accept(1'b0, 3);
    grant(15);
    drain();
    check("rd_total", charge_total, 27);

    // timeout after 64 POLICY cycles, then a late grant is ignored
    accept(1'b1, 1);
    step(63);
    check("tmo_before", tmo_cnt, 0);
    check("tmo_busy", txn_ready, 0);
    step(1);
    check("tmo_cnt", tmo_cnt, 1);
    check("tmo_ready", txn_ready, 1);
    check_policy = 1'b1;
    step(1);
    check_policy = 1'b0;
    step(12);
    check("tmo_grants", grant_cnt, 3);
    check("tmo_deny", deny_cnt, 1);
    check("tmo_total", charge_total, 27);

    // budget 20: second write crosses it
    do_clr();
    check("clr_total", charge_total, 0);
    check("clr_grants", grant_cnt, 0);
    check("clr_deny", deny_cnt, 0);
    check("clr_tmo", tmo_cnt, 0);
    cfg_budget = 24'd20;
    accept(1'b1, 4);
    grant(12);
    drain();
    check("bud1_over", over_budget, 0);
    accept(1'b1, 4);
    grant(12);
    drain();
    check("bud2_over", over_budget, 1);
    check("bud2_ready", txn_ready, 0);
    check("bud2_total", charge_total, 24);
    do_clr();
    check("bclr_total", charge_total, 0);
    check("bclr_grants", grant_cnt, 0);
    check("bclr_over", over_budget, 0);
    check("bclr_ready", txn_ready, 1);

    // clr coinciding with accept drops the request
    txn_valid = 1'b1; txn_wr = 1'b1; txn_len = 8'd4; clr = 1'b1;
    step(1);
    txn_valid = 1'b0; clr = 1'b0;
    check("clracc_ready", txn_ready, 1);
    check_policy = 1'b1;
    step(1);
    check_policy = 1'b0;
    step(12);
    check("clracc_grants", grant_cnt, 0);

    // clr during MULT aborts without counting
    cfg_budget = 24'hFFFFFF;
    accept(1'b1, 4);
    check_policy = 1'b1;
    step(1);
    check_policy = 1'b0;
    step(3);
    check("mult_busy", txn_ready, 0);
    do_clr();
    check("abort_ready", txn_ready, 1);
    step(12);
    check("abort_grants", grant_cnt, 0);
    check("abort_total", charge_total, 0);

    // 259 maximal charges: 258*65025 = 16776450, the next saturates
    cfg_wr_cost = 8'd255;
    for (int i = 0; i < 259; i++) begin
      accept(1'b1, 255);
      grant(65025);
      drain();
    end
    check("sat_total", charge_total, 24'hFFFFFF);
    check("sat_grants", grant_cnt, 259);
    check("sat_over", over_budget, 1);
    check("sat_ready", txn_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
